// File: rtl/jmp_rvs_if.sv
// Dispatch, CDB and issue signals of the jmp reservation queue.
// The queue itself uses the slave modport; the dispatch/issue side uses master.
interface jmp_rvs_if #(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 4,
    parameter int ROB_PTR_W = 4,
    parameter int OPC_W     = 4
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic                 flush;

    logic                 dis_req;
    logic                 dis_rdy;
    logic [OPC_W-1:0]     dis_opc;
    logic [ROB_PTR_W-1:0] dis_inst_id;
    logic [TAG_W-1:0]     dis_tag;
    logic                 dis_s1_vld;
    logic [TAG_W-1:0]     dis_s1_tag;
    logic [31:0]          dis_s1_data;
    logic                 dis_s2_vld;
    logic [TAG_W-1:0]     dis_s2_tag;
    logic [31:0]          dis_s2_data;
    logic [11:0]          dis_offset;

    logic                 cdb_req;
    logic [TAG_W-1:0]     cdb_tag;
    logic [31:0]          cdb_wdata;

    logic                 iss_req;
    logic                 iss_rdy;
    logic [OPC_W-1:0]     iss_opc;
    logic [ROB_PTR_W-1:0] iss_inst_id;
    logic [TAG_W-1:0]     iss_tag;
    logic [11:0]          iss_offset;
    logic [31:0]          iss_src1;
    logic [31:0]          iss_src2;

    logic [OCC_W-1:0]     occ;

    modport slave (
        input  flush,
        input  dis_req, dis_opc, dis_inst_id, dis_tag,
        input  dis_s1_vld, dis_s1_tag, dis_s1_data,
        input  dis_s2_vld, dis_s2_tag, dis_s2_data, dis_offset,
        input  cdb_req, cdb_tag, cdb_wdata,
        input  iss_rdy,
        output dis_rdy,
        output iss_req, iss_opc, iss_inst_id, iss_tag, iss_offset, iss_src1, iss_src2,
        output occ
    );

    modport master (
        output flush,
        output dis_req, dis_opc, dis_inst_id, dis_tag,
        output dis_s1_vld, dis_s1_tag, dis_s1_data,
        output dis_s2_vld, dis_s2_tag, dis_s2_data, dis_offset,
        output cdb_req, cdb_tag, cdb_wdata,
        output iss_rdy,
        input  dis_rdy,
        input  iss_req, iss_opc, iss_inst_id, iss_tag, iss_offset, iss_src1, iss_src2,
        input  occ
    );
endinterface

// File: rtl/jmp_rvs.sv
// In-order reservation queue for branch/jump ops: captures operands from the CDB
// and issues only the oldest entry, once both of its operands are ready.
module jmp_rvs #(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 4,
    parameter int ROB_PTR_W = 4,
    parameter int OPC_W     = 4
) (
    input  logic     clk,
    input  logic     rst,
    jmp_rvs_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic                 vld;
        logic [OPC_W-1:0]     opc;
        logic [ROB_PTR_W-1:0] inst_id;
        logic [TAG_W-1:0]     tag;
        logic [11:0]          offset;
        logic                 s1_rdy;
        logic [TAG_W-1:0]     s1_tag;
        logic [31:0]          s1_data;
        logic                 s2_rdy;
        logic [TAG_W-1:0]     s2_tag;
        logic [31:0]          s2_data;
    } ent_t;

    ent_t           ent_q [DEPTH];
    ent_t           ent_d [DEPTH];
    logic [PTR_W:0] wptr_q, wptr_d;
    logic [PTR_W:0] rptr_q, rptr_d;

    logic [PTR_W-1:0] wix, rix;
    logic             full, empty;
    logic             push, pop;
    logic             s1_hit, s2_hit;
    ent_t             head;
    ent_t             new_ent;

    assign wix   = wptr_q[PTR_W-1:0];
    assign rix   = rptr_q[PTR_W-1:0];
    assign full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) && (wix == rix);
    assign empty = (wptr_q == rptr_q);
    assign head  = ent_q[rix];

    // Issue looks only at the head; younger ready entries wait behind it.
    assign bus.iss_req     = !empty && head.vld && head.s1_rdy && head.s2_rdy && !bus.flush;
    assign bus.iss_opc     = head.opc;
    assign bus.iss_inst_id = head.inst_id;
    assign bus.iss_tag     = head.tag;
    assign bus.iss_offset  = head.offset;
    assign bus.iss_src1    = head.s1_data;
    assign bus.iss_src2    = head.s2_data;

    assign bus.dis_rdy = !full;
    assign bus.occ     = wptr_q - rptr_q;

    assign push = bus.dis_req && !full;
    assign pop  = bus.iss_req && bus.iss_rdy;

    assign s1_hit = bus.cdb_req && (bus.cdb_tag == bus.dis_s1_tag);
    assign s2_hit = bus.cdb_req && (bus.cdb_tag == bus.dis_s2_tag);

    // A source broadcast in the dispatch cycle is captured directly.
    always_comb begin
        new_ent         = '0;
        new_ent.vld     = 1'b1;
        new_ent.opc     = bus.dis_opc;
        new_ent.inst_id = bus.dis_inst_id;
        new_ent.tag     = bus.dis_tag;
        new_ent.offset  = bus.dis_offset;
        new_ent.s1_tag  = bus.dis_s1_tag;
        new_ent.s2_tag  = bus.dis_s2_tag;
        new_ent.s1_rdy  = bus.dis_s1_vld || s1_hit;
        new_ent.s1_data = bus.dis_s1_vld ? bus.dis_s1_data : bus.cdb_wdata;
        new_ent.s2_rdy  = bus.dis_s2_vld || s2_hit;
        new_ent.s2_data = bus.dis_s2_vld ? bus.dis_s2_data : bus.cdb_wdata;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end
        wptr_d = wptr_q;
        rptr_d = rptr_q;

        if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].vld = 1'b0;
            end
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (bus.cdb_req) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ent_q[i].vld && !ent_q[i].s1_rdy && (ent_q[i].s1_tag == bus.cdb_tag)) begin
                        ent_d[i].s1_rdy  = 1'b1;
                        ent_d[i].s1_data = bus.cdb_wdata;
                    end
                    if (ent_q[i].vld && !ent_q[i].s2_rdy && (ent_q[i].s2_tag == bus.cdb_tag)) begin
                        ent_d[i].s2_rdy  = 1'b1;
                        ent_d[i].s2_data = bus.cdb_wdata;
                    end
                end
            end
            if (pop) begin
                ent_d[rix].vld = 1'b0;
                rptr_d         = rptr_q + (PTR_W+1)'(1);
            end
            if (push) begin
                ent_d[wix] = new_ent;
                wptr_d     = wptr_q + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end
endmodule

// File: tb/tb_jmp_rvs.sv
// Bench for jmp_rvs: directed scenarios plus random traffic, all checked
// against a queue-based model of the reservation station.
module tb_jmp_rvs;
    localparam int DEPTH     = 4;
    localparam int TAG_W     = 4;
    localparam int ROB_PTR_W = 4;
    localparam int OPC_W     = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jmp_rvs_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ROB_PTR_W(ROB_PTR_W), .OPC_W(OPC_W)) bus ();

    jmp_rvs #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ROB_PTR_W(ROB_PTR_W), .OPC_W(OPC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [3:0]  opc;
        logic [3:0]  id;
        logic [3:0]  tag;
        logic [11:0] off;
        bit          r1;
        bit          r2;
        logic [3:0]  t1;
        logic [3:0]  t2;
        logic [31:0] d1;
        logic [31:0] d2;
    } op_t;

    op_t mq[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: compare outputs with the model, then advance the model at the edge.
    task automatic step();
        int  n;
        bit  er, eq;
        op_t o;
        n  = mq.size();
        er = (n < DEPTH);
        eq = (n > 0) && mq[0].r1 && mq[0].r2 && !bus.flush;
        #1;
        if (!rst) begin
            chk("dis_rdy", 32'(bus.dis_rdy), 32'(er));
            chk("iss_req", 32'(bus.iss_req), 32'(eq));
            chk("occ", 32'(bus.occ), 32'(n));
            if (eq) begin
                chk("iss_opc", 32'(bus.iss_opc), 32'(mq[0].opc));
                chk("iss_inst_id", 32'(bus.iss_inst_id), 32'(mq[0].id));
                chk("iss_tag", 32'(bus.iss_tag), 32'(mq[0].tag));
                chk("iss_offset", 32'(bus.iss_offset), 32'(mq[0].off));
                chk("iss_src1", bus.iss_src1, mq[0].d1);
                chk("iss_src2", bus.iss_src2, mq[0].d2);
            end
        end
        @(posedge clk);
        if (rst || bus.flush) begin
            mq.delete();
        end else begin
            if (bus.cdb_req) begin
                foreach (mq[i]) begin
                    if (!mq[i].r1 && mq[i].t1 == bus.cdb_tag) begin mq[i].r1 = 1; mq[i].d1 = bus.cdb_wdata; end
                    if (!mq[i].r2 && mq[i].t2 == bus.cdb_tag) begin mq[i].r2 = 1; mq[i].d2 = bus.cdb_wdata; end
                end
            end
            if (eq && bus.iss_rdy) void'(mq.pop_front());
            if (bus.dis_req && er) begin
                o.opc = bus.dis_opc;
                o.id  = bus.dis_inst_id;
                o.tag = bus.dis_tag;
                o.off = bus.dis_offset;
                o.t1  = bus.dis_s1_tag;
                o.t2  = bus.dis_s2_tag;
                o.r1  = bus.dis_s1_vld || (bus.cdb_req && bus.cdb_tag == bus.dis_s1_tag);
                o.r2  = bus.dis_s2_vld || (bus.cdb_req && bus.cdb_tag == bus.dis_s2_tag);
                o.d1  = bus.dis_s1_vld ? bus.dis_s1_data : bus.cdb_wdata;
                o.d2  = bus.dis_s2_vld ? bus.dis_s2_data : bus.cdb_wdata;
                mq.push_back(o);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.dis_req = 1'b0;
        bus.cdb_req = 1'b0;
        bus.flush   = 1'b0;
    endtask

    task automatic dis(input logic [3:0] opc, input logic [3:0] id, input logic [3:0] tag,
                       input bit v1, input logic [3:0] t1, input logic [31:0] d1,
                       input bit v2, input logic [3:0] t2, input logic [31:0] d2);
        bus.dis_req     = 1'b1;
        bus.dis_opc     = opc;
        bus.dis_inst_id = id;
        bus.dis_tag     = tag;
        bus.dis_s1_vld  = v1;
        bus.dis_s1_tag  = t1;
        bus.dis_s1_data = d1;
        bus.dis_s2_vld  = v2;
        bus.dis_s2_tag  = t2;
        bus.dis_s2_data = d2;
        bus.dis_offset  = 12'($urandom);
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
        bus.cdb_req   = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_wdata = data;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        dis(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.dis_req = 1'b0;
        cdb(0, 0);
        bus.cdb_req = 1'b0;
        bus.iss_rdy = 1'b0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        step();

        // beq with both sources valid issues the cycle after dispatch
        bus.iss_rdy = 1'b1;
        dis(4'h1, 4'd1, 4'd2, 1, 4'd0, 32'd5, 1, 4'd0, 32'd5);
        step();
        idle();
        chk("t1_req", 32'(bus.iss_req), 32'd1);
        chk("t1_src1", bus.iss_src1, 32'd5);
        chk("t1_src2", bus.iss_src2, 32'd5);
        step();
        chk("t1_occ", 32'(bus.occ), 32'd0);

        // bne waits for tag 3, broadcast two cycles later
        dis(4'h2, 4'd2, 4'd4, 0, 4'd3, 32'd0, 1, 4'd0, 32'd7);
        step();
        idle();
        step();
        cdb(4'd3, 32'h10);
        step();
        idle();
        chk("t2_req", 32'(bus.iss_req), 32'd1);
        chk("t2_src1", bus.iss_src1, 32'h10);
        step();

        // fill with a pending head, wake it, then push+pop together
        for (int i = 0; i < 4; i++) begin
            dis(4'h3, 4'(4 + i), 4'(i), i != 0, 4'd9, 32'(i), 1, 4'd0, 32'(100 + i));
            step();
        end
        idle();
        chk("t3_full", 32'(bus.dis_rdy), 32'd0);
        chk("t3_block", 32'(bus.iss_req), 32'd0);
        cdb(4'd9, 32'h99);
        step();
        idle();
        chk("t3_head_id", 32'(bus.iss_inst_id), 32'd4);
        step();
        dis(4'h3, 4'd8, 4'd5, 1, 4'd0, 32'd1, 1, 4'd0, 32'd2);
        step();
        idle();
        chk("t3_occ", 32'(bus.occ), 32'd3);
        repeat (5) step();

        // source woken by the CDB in the dispatch cycle
        dis(4'h4, 4'd9, 4'd6, 1, 4'd0, 32'd1, 0, 4'd7, 32'd0);
        cdb(4'd7, 32'hABCD);
        step();
        idle();
        chk("t4_req", 32'(bus.iss_req), 32'd1);
        chk("t4_src2", bus.iss_src2, 32'hABCD);
        step();

        // stall then pointer wrap
        bus.iss_rdy = 1'b0;
        dis(4'h5, 4'd10, 4'd1, 1, 4'd0, 32'h55, 1, 4'd0, 32'h66);
        step();
        idle();
        repeat (3) step();
        bus.iss_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            dis(4'h6, 4'(i), 4'(i), 1, 4'd0, 32'(i * 3), 1, 4'd0, 32'(i * 5));
            step();
        end
        idle();
        repeat (2) step();

        // flush with 3 entries and a concurrent dispatch
        bus.iss_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dis(4'h7, 4'(i), 4'(i), 0, 4'd12, 32'd0, 1, 4'd0, 32'd1);
            step();
        end
        dis(4'h7, 4'd3, 4'd3, 1, 4'd0, 32'd1, 1, 4'd0, 32'd1);
        bus.flush = 1'b1;
        step();
        idle();
        chk("t6_occ", 32'(bus.occ), 32'd0);
        chk("t6_req", 32'(bus.iss_req), 32'd0);
        chk("t6_rdy", 32'(bus.dis_rdy), 32'd1);
        cdb(4'd12, 32'hDEAD);
        step();
        idle();
        chk("t6_stale", 32'(bus.occ), 32'd0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            dis(4'($urandom), 4'($urandom), 4'($urandom),
                $urandom_range(0, 2) == 0, 4'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 2) == 0, 4'($urandom_range(0, 7)), $urandom);
            bus.dis_req = 1'($urandom_range(0, 1));
            cdb(4'($urandom_range(0, 7)), $urandom);
            bus.cdb_req = 1'($urandom_range(0, 1));
            bus.flush   = ($urandom_range(0, 49) == 0);
            bus.iss_rdy = ($urandom_range(0, 3) != 0);
            rst         = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
